seven_seg_array: RTL and testbench
==================================

SEVEN_SEG_ARRAY -- requirements
Module: seven_seg_array

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 6, number of hex digits driven (1..8).
REQ-002 SHALL have parameter BLINK_DIV, default 25000000, clk cycles per blink half-period (>=2).
REQ-003 SHALL have parameter ACTIVE_LOW, default 1; 1 means a lit segment is driven 0.
REQ-004 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port address  input  2  Avalon-MM register select.
REQ-007 SHALL have port chipselect  input  1  Avalon-MM slave select.
REQ-008 SHALL have port write  input  1  write strobe, qualified by chipselect.
REQ-009 SHALL have port writedata  input  32  write data.
REQ-010 SHALL have port read  input  1  read strobe, qualified by chipselect.
REQ-011 SHALL have port readdata  output  32  registered read data.
REQ-012 SHALL have port segs  output  7*NUM_DIGITS  segments, digit d at bits [7d+6:7d], bit0=a .. bit6=g.
REQ-013 SHALL have port dp  output  NUM_DIGITS  decimal points, bit d = digit d, same polarity as segs.

Function
REQ-014 Registers SHALL be: addr0 DATA[4*NUM_DIGITS-1:0] (nibble d = digit d); addr1 CTRL[2:0] (bit0 enable, bit1 leading-zero suppress, bit2 blink); addr2 BLANK[NUM_DIGITS-1:0]; addr3 DPMASK[NUM_DIGITS-1:0].
REQ-015 A write SHALL occur on an edge with chipselect=1 and write=1; the register takes writedata's low bits at that edge, upper writedata bits ignored.
REQ-016 A read SHALL occur on an edge with chipselect=1, read=1, write=0; readdata holds the zero-extended register one cycle later and keeps that value until the next read.
REQ-017 chipselect=1 with read=1 and write=1 SHALL perform the write only; readdata unchanged.
REQ-018 segs/dp SHALL be registered: a register write at edge k is visible on segs/dp after edge k+1 (one-cycle latency).
REQ-019 Hex encoding SHALL be standard (0-9, A, b, C, d, E, F); with ACTIVE_LOW=1: 0=0x40, 1=0x79, 8=0x00, A=0x08, F=0x0E; ACTIVE_LOW=0 inverts all segs and dp.
REQ-020 Digit d SHALL be blank (all segs and dp off) if CTRL.enable=0, or BLANK[d]=1, or blink phase is off (REQ-023).
REQ-021 With CTRL bit1=1, digit d>0 SHALL be blank when all nibbles d..NUM_DIGITS-1 are zero; digit 0 is never suppressed; dp of a suppressed digit is off.
REQ-022 Otherwise dp[d] SHALL be lit iff DPMASK[d]=1.
REQ-023 Blink: with CTRL bit2=1, a counter runs 0..BLINK_DIV-1, wraps to 0 and toggles phase on wrap; phase 1 = off; first off phase begins BLINK_DIV cycles after blink enable.
REQ-024 With CTRL bit2=0, the blink counter SHALL be held at 0 and phase at 0 (on).
REQ-025 Writing CTRL with bit2 changing 1->0 SHALL restore display on the next cycle's output (REQ-018 latency).

Reset
REQ-026 reset=1 at an edge SHALL set DATA=0, CTRL=0x1, BLANK=0, DPMASK=0, blink counter=0, phase=0, readdata=0, and all segs/dp off.
REQ-027 reset SHALL override a simultaneous write or read.
REQ-028 After reset deasserts, segs SHALL show "0" on every digit one edge later.

Verification (NUM_DIGITS=6, ACTIVE_LOW=1, BLINK_DIV=4)
REQ-029 Reset 2 cycles, release -> one cycle later segs=all digits 0x40, dp=6'h3F, readdata=0.
REQ-030 Write addr0 0x00FEDCBA, then read addr0 -> next cycle digits 0..5 = A,b,C,d,E,F encodings; readdata=0x00FEDCBA.
REQ-031 Write DATA=0x000012, CTRL=0x3 -> digits 0,1 show 2,1; digits 2..5 = 0x7F; then BLANK=0x01 -> digit 0 = 0x7F.
REQ-032 DPMASK=0x05 -> dp=6'b111010; CTRL=0x0 -> segs all 0x7F, dp=6'h3F.
REQ-033 CTRL=0x5 -> segs on 4 cycles, off 4 cycles, repeating; write CTRL=0x1 mid-off -> on after one cycle.
REQ-034 Assert reset during blink-off with a simultaneous write -> write lost, REQ-026 values, counter restarts at 0.

Source files
------------

// File: rtl/seven_seg_array.sv
// Avalon-MM controlled bank of hex seven-segment digits with blank, leading-zero suppress, decimal points and blink.
// Latency: readdata one cycle after a read; segs/dp one cycle after any register or blink-phase change.
// Backpressure: none; the slave accepts every access with zero wait states.
module seven_seg_array #(
    parameter int NUM_DIGITS = 6,
    parameter int BLINK_DIV  = 25000000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [1:0]              address,
    input  logic                    chipselect,
    input  logic                    write,
    input  logic [31:0]             writedata,
    input  logic                    read,
    output logic [31:0]             readdata,
    output logic [7*NUM_DIGITS-1:0] segs,
    output logic [NUM_DIGITS-1:0]   dp
);

    localparam int             DW       = 4 * NUM_DIGITS;
    localparam int             CW       = $clog2(BLINK_DIV);
    localparam logic [CW-1:0]  CNT_LAST = CW'(BLINK_DIV - 1);
    localparam logic           OFF_LVL  = (ACTIVE_LOW != 0);

    logic [DW-1:0]          data_reg;
    logic [2:0]             ctrl_reg;
    logic [NUM_DIGITS-1:0]  blank_reg;
    logic [NUM_DIGITS-1:0]  dpmask_reg;
    logic [CW-1:0]          blink_cnt;
    logic                   blink_phase;

    logic                   wr_en;
    logic                   rd_en;
    logic                   blink_off;
    logic [31:0]            rd_mux;
    logic [7*NUM_DIGITS-1:0] segs_nxt;
    logic [NUM_DIGITS-1:0]  dp_nxt;
    logic [3:0]             nib;
    logic                   zero_run;
    logic                   dark;
    logic [6:0]             seg_on;
    logic                   unused_wdata;

    assign unused_wdata = ^writedata;

    // A simultaneous read and write is treated as a write only.
    assign wr_en = chipselect & write;
    assign rd_en = chipselect & read & ~write;

    // Gating on the enable bit as well lets a blink-disable take effect without waiting for the phase to clear.
    assign blink_off = ctrl_reg[2] & blink_phase;

    // Active-high segment patterns, bit0 = a .. bit6 = g.
    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] p;
        case (n)
            4'h0: p = 7'h3F;
            4'h1: p = 7'h06;
            4'h2: p = 7'h5B;
            4'h3: p = 7'h4F;
            4'h4: p = 7'h66;
            4'h5: p = 7'h6D;
            4'h6: p = 7'h7D;
            4'h7: p = 7'h07;
            4'h8: p = 7'h7F;
            4'h9: p = 7'h6F;
            4'hA: p = 7'h77;
            4'hB: p = 7'h7C;
            4'hC: p = 7'h39;
            4'hD: p = 7'h5E;
            4'hE: p = 7'h79;
            default: p = 7'h71;
        endcase
        return p;
    endfunction

    always_comb begin
        rd_mux = '0;
        case (address)
            2'd0: rd_mux[DW-1:0]         = data_reg;
            2'd1: rd_mux[2:0]            = ctrl_reg;
            2'd2: rd_mux[NUM_DIGITS-1:0] = blank_reg;
            2'd3: rd_mux[NUM_DIGITS-1:0] = dpmask_reg;
        endcase
    end

    // Walk from the most significant digit down so zero_run means "this digit and all above are zero".
    always_comb begin
        segs_nxt = '0;
        dp_nxt   = '0;
        nib      = '0;
        zero_run = 1'b1;
        dark     = 1'b0;
        seg_on   = '0;
        for (int d = NUM_DIGITS - 1; d >= 0; d--) begin
            nib      = data_reg[4*d +: 4];
            zero_run = zero_run & (nib == 4'd0);
            dark     = !ctrl_reg[0] || blank_reg[d] || blink_off ||
                       (ctrl_reg[1] && (d != 0) && zero_run);
            seg_on   = dark ? 7'd0 : hex7(nib);
            segs_nxt[7*d +: 7] = seg_on ^ {7{OFF_LVL}};
            dp_nxt[d]          = (!dark && dpmask_reg[d]) ^ OFF_LVL;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_reg    <= '0;
            ctrl_reg    <= 3'b001;
            blank_reg   <= '0;
            dpmask_reg  <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            readdata    <= '0;
            segs        <= {(7*NUM_DIGITS){OFF_LVL}};
            dp          <= {NUM_DIGITS{OFF_LVL}};
        end else begin
            if (wr_en) begin
                case (address)
                    2'd0: data_reg   <= writedata[DW-1:0];
                    2'd1: ctrl_reg   <= writedata[2:0];
                    2'd2: blank_reg  <= writedata[NUM_DIGITS-1:0];
                    2'd3: dpmask_reg <= writedata[NUM_DIGITS-1:0];
                endcase
            end
            if (rd_en)
                readdata <= rd_mux;

            if (!ctrl_reg[2]) begin
                blink_cnt   <= '0;
                blink_phase <= 1'b0;
            end else if (blink_cnt == CNT_LAST) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end

            segs <= segs_nxt;
            dp   <= dp_nxt;
        end
    end

endmodule

// File: tb/tb_seven_seg_array.sv
// Directed self-checking bench for seven_seg_array with six digits, active-low outputs and a four-cycle blink half-period.
module tb_seven_seg_array;

    localparam logic [6:0] S0 = 7'h40;
    localparam logic [6:0] S1 = 7'h79;
    localparam logic [6:0] S2 = 7'h24;
    localparam logic [6:0] SA = 7'h08;
    localparam logic [6:0] SB = 7'h03;
    localparam logic [6:0] SC = 7'h46;
    localparam logic [6:0] SD = 7'h21;
    localparam logic [6:0] SE = 7'h06;
    localparam logic [6:0] SF = 7'h0E;
    localparam logic [6:0] SX = 7'h7F;
    localparam logic [41:0] ALL_OFF = {SX, SX, SX, SX, SX, SX};
    localparam logic [41:0] ALL_0   = {S0, S0, S0, S0, S0, S0};
    localparam logic [41:0] ON_12   = {S0, S0, S0, S0, S1, S2};
    localparam logic [5:0]  DP_OFF  = 6'h3F;
    localparam logic [5:0]  DP_05   = 6'b111010;

    logic        clk;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write;
    logic [31:0] writedata;
    logic        read;
    logic [31:0] readdata;
    logic [41:0] segs;
    logic [5:0]  dp;

    int n_cmp;
    int n_err;

    seven_seg_array #(
        .NUM_DIGITS (6),
        .BLINK_DIV  (4),
        .ACTIVE_LOW (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write      (write),
        .writedata  (writedata),
        .read       (read),
        .readdata   (readdata),
        .segs       (segs),
        .dp         (dp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write      = 1'b1;
        address    = a;
        writedata  = d;
        step();
        chipselect = 1'b0;
        write      = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a);
        chipselect = 1'b1;
        read       = 1'b1;
        address    = a;
        step();
        chipselect = 1'b0;
        read       = 1'b0;
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        reset      = 1'b1;
        chipselect = 1'b0;
        write      = 1'b0;
        read       = 1'b0;
        address    = 2'd0;
        writedata  = 32'd0;

        step();
        step();
        chk("rst_segs", segs, ALL_OFF);
        chk("rst_dp", dp, DP_OFF);
        chk("rst_rd", readdata, 32'd0);

        reset = 1'b0;
        step();
        chk("post_rst_segs", segs, ALL_0);
        chk("post_rst_dp", dp, DP_OFF);
        chk("post_rst_rd", readdata, 32'd0);

        // Upper writedata bits must be dropped.
        wr(2'd0, 32'hFFFEDCBA);
        rd(2'd0);
        chk("hex_segs", segs, {SF, SE, SD, SC, SB, SA});
        chk("rd_data", readdata, 32'h00FEDCBA);
        step();
        chk("rd_hold", readdata, 32'h00FEDCBA);

        wr(2'd0, 32'h12);
        wr(2'd1, 32'h3);
        step();
        chk("lz_segs", segs, {SX, SX, SX, SX, S1, S2});
        chk("lz_dp", dp, DP_OFF);
        wr(2'd2, 32'h1);
        step();
        chk("blank_d0", segs, {SX, SX, SX, SX, S1, SX});
        wr(2'd2, 32'h0);
        wr(2'd0, 32'h102);
        step();
        chk("lz_mid_zero", segs, {SX, SX, SX, S1, S0, S2});
        wr(2'd0, 32'h0);
        step();
        chk("lz_digit0", segs, {SX, SX, SX, SX, SX, S0});

        wr(2'd0, 32'h12);
        wr(2'd1, 32'h1);
        wr(2'd3, 32'h5);
        step();
        chk("dpmask_segs", segs, ON_12);
        chk("dpmask_dp", dp, DP_05);
        wr(2'd1, 32'h0);
        step();
        chk("disable_segs", segs, ALL_OFF);
        chk("disable_dp", dp, DP_OFF);
        rd(2'd3);
        chk("rd_dpmask", readdata, 32'h5);
        rd(2'd1);
        chk("rd_ctrl", readdata, 32'h0);

        // Read and write together: write lands, readdata keeps the previous value.
        chipselect = 1'b1;
        read       = 1'b1;
        write      = 1'b1;
        address    = 2'd2;
        writedata  = 32'hFFFF_FF3F;
        step();
        chipselect = 1'b0;
        read       = 1'b0;
        write      = 1'b0;
        step();
        chk("rw_rd_unchanged", readdata, 32'h0);
        rd(2'd2);
        chk("rw_write_done", readdata, 32'h3F);
        wr(2'd2, 32'h0);

        wr(2'd1, 32'h5);
        for (int i = 1; i <= 14; i++) begin
            step();
            if (((i - 1) / 4) % 2 == 0) begin
                chk($sformatf("blink_on_%0d", i), segs, ON_12);
                chk($sformatf("blink_on_dp_%0d", i), dp, DP_05);
            end else begin
                chk($sformatf("blink_off_%0d", i), segs, ALL_OFF);
                chk($sformatf("blink_off_dp_%0d", i), dp, DP_OFF);
            end
        end
        wr(2'd1, 32'h1);
        chk("blink_still_off", segs, ALL_OFF);
        step();
        chk("blink_restore", segs, ON_12);
        chk("blink_restore_dp", dp, DP_05);

        // Reset during an off phase with a competing write.
        wr(2'd1, 32'h5);
        for (int i = 1; i <= 5; i++) step();
        chk("pre_rst_off", segs, ALL_OFF);
        reset      = 1'b1;
        chipselect = 1'b1;
        write      = 1'b1;
        address    = 2'd0;
        writedata  = 32'h99;
        step();
        chk("mid_rst_segs", segs, ALL_OFF);
        chk("mid_rst_rd", readdata, 32'd0);
        reset      = 1'b0;
        chipselect = 1'b0;
        write      = 1'b0;
        step();
        chk("rst2_segs", segs, ALL_0);
        chk("rst2_dp", dp, DP_OFF);
        rd(2'd0);
        chk("rst2_data_lost", readdata, 32'd0);
        rd(2'd1);
        chk("rst2_ctrl", readdata, 32'h1);

        wr(2'd1, 32'h5);
        for (int i = 1; i <= 5; i++) begin
            step();
            if (i <= 4)
                chk($sformatf("restart_on_%0d", i), segs, ALL_0);
            else
                chk($sformatf("restart_off_%0d", i), segs, ALL_OFF);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
